cyber_player: RTL

CYBER_PLAYER -- requirements
Module: cyber_player

---
 rtl/cyber_player.sv | 116 +++++++++++
 1 files changed

// File: rtl/cyber_player.sv
// Computer opponent for the reaction game: a pseudo-random press generator paced
// by a prescaler tick, with one press at most every other tick.
module cyber_player #(
    parameter int unsigned TICK_DIV = 15,
    parameter logic [9:0]  SEED     = 10'h2A5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [8:0] difficulty,
    input  logic       freeze,
    output logic       press,
    output logic [9:0] lfsr_value
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS    = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    localparam logic [TICK_DIV-1:0] PRE_ONE = TICK_DIV'(1);
    localparam logic [TICK_DIV-1:0] PRE_ZERO = TICK_DIV'(0);

    logic [TICK_DIV-1:0] prescaler_r;
    logic [9:0]          lfsr_r;
    state_t              state_r;
    logic                press_r;
    logic                tick_s;
    logic                fire_s;
    logic                hold_s;

    // x^10 + x^7 + 1, shifting toward the MSB
    function automatic logic [9:0] lfsr_next(input logic [9:0] cur);
        lfsr_next = {cur[8:0], cur[9] ^ cur[6]};
    endfunction

    // Free-running tick prescaler
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler_r <= PRE_ZERO;
        end else begin
            prescaler_r <= prescaler_r + PRE_ONE;
        end
    end

    // LFSR advances only on ticks; an all-zero state is recovered immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_r <= SEED;
        end else if (lfsr_r == 10'd0) begin
            lfsr_r <= SEED;
        end else if (tick_s) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    // Tick, fire decision and hold-off condition
    always_comb begin
        tick_s = &prescaler_r;
        hold_s = !enable || freeze;
        fire_s = 1'b0;
        if (tick_s && !hold_s && ({1'b0, difficulty} > lfsr_r)) begin
            fire_s = 1'b1;
        end else begin
            fire_s = 1'b0;
        end
    end

    // Press sequencer; the press output is the registered PRESS state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            press_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (fire_s) begin
                        state_r <= PRESS;
                        press_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        press_r <= 1'b0;
                    end
                end
                PRESS: begin
                    press_r <= 1'b0;
                    // the press pulse itself is never cut short, only the cooldown
                    if (hold_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    press_r <= 1'b0;
                    if (hold_s || tick_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= COOLDOWN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    press_r <= 1'b0;
                end
            endcase
        end
    end

    assign press      = press_r;
    assign lfsr_value = lfsr_r;

endmodule
